// File: rtl/sseg_scan_driver_if.sv
// sseg_scan_driver_if
//   Bundles the display-data inputs and the pin-side outputs of sseg_scan_driver.
//   master : data source (calculator datapath / bench) - drives value, dp_in,
//            blank_in, lzs_en, load; observes an, sseg, frame.
//   slave  : the scan driver itself.
//   value    4*N_DIGITS  hex digits, digit i = value[4i+3:4i]
//   dp_in    N_DIGITS    decimal point per digit, active-high
//   blank_in N_DIGITS    force digit dark, active-high
//   lzs_en   1           leading-zero suppression enable (live level)
//   load     1           1-cycle strobe capturing value/dp_in/blank_in
//   an       N_DIGITS    anodes, active-low
//   sseg     8           {dp,g,f,e,d,c,b,a} cathodes, active-low
//   frame    1           1-cycle pulse after each frame wrap
interface sseg_scan_driver_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blank_in;
  logic                  lzs_en;
  logic                  load;
  logic [N_DIGITS-1:0]   an;
  logic [7:0]            sseg;
  logic                  frame;

  modport master (
    output value, dp_in, blank_in, lzs_en, load,
    input  an, sseg, frame
  );

  modport slave (
    input  value, dp_in, blank_in, lzs_en, load,
    output an, sseg, frame
  );
endinterface

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver
//   Time-multiplexed N-digit seven-segment driver. One digit is lit per slot of
//   CLKS_PER_DIGIT cycles; the first BLANK_CLKS cycles of every slot keep all
//   anodes off to avoid ghosting. Display data is double buffered: load writes
//   a staging copy, which is moved into the displayed (shadow) copy only at a
//   frame wrap, so a frame never mixes old and new digits.
// Ports
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      sseg_scan_driver_if.slave (data in, an/sseg/frame out, all
//            outputs registered, one cycle behind the scan state)

// Per-digit decode: hex nibble to active-low {dp,gfedcba}. A dark digit keeps
// its segments off but still drives its decimal point.
module sseg_digit (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       dark,
  output logic [7:0] pat
);
  logic [6:0] seg;

  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

  assign pat = {~dp, dark ? 7'h7F : seg};
endmodule

module sseg_scan_driver #(
  parameter int N_DIGITS       = 4,
  parameter int CLKS_PER_DIGIT = 100000,
  parameter int BLANK_CLKS     = 1000
) (
  input  logic               clk,
  input  logic               reset_n,
  sseg_scan_driver_if.slave  bus
);
  localparam int CW = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;

  logic [N_DIGITS-1:0][3:0] stg_val, sh_val;
  logic [N_DIGITS-1:0]      stg_dp, sh_dp;
  logic [N_DIGITS-1:0]      stg_bl, sh_bl;
  logic                     pending;

  logic [N_DIGITS-1:0]      an_q;
  logic [7:0]               sseg_q;
  logic                     frame_q;

  logic                     tc, last, fb;
  logic [N_DIGITS-1:0]      sel, sup;
  logic [N_DIGITS-1:0][7:0] lane_pat;
  logic [7:0]               sseg_mux;
  logic                     zrun;

  assign tc   = (cnt == CW'(CLKS_PER_DIGIT - 1));
  assign last = (idx == IW'(N_DIGITS - 1));
  assign fb   = tc & last;

  // Slot counter and digit index; explicit compare-and-clear, no wrap by overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (tc) begin
      cnt <= '0;
      idx <= last ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Double buffer. A load landing exactly on the frame wrap bypasses staging
  // so it is shown in the very next frame instead of waiting a whole frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_val <= '0;
      stg_dp  <= '0;
      stg_bl  <= '0;
      sh_val  <= '0;
      sh_dp   <= '0;
      sh_bl   <= '0;
      pending <= 1'b0;
    end else begin
      if (bus.load) begin
        stg_val <= bus.value;
        stg_dp  <= bus.dp_in;
        stg_bl  <= bus.blank_in;
      end
      if (fb) begin
        pending <= 1'b0;
        if (bus.load) begin
          sh_val <= bus.value;
          sh_dp  <= bus.dp_in;
          sh_bl  <= bus.blank_in;
        end else if (pending) begin
          sh_val <= stg_val;
          sh_dp  <= stg_dp;
          sh_bl  <= stg_bl;
        end
      end else if (bus.load) begin
        pending <= 1'b1;
      end
    end
  end

  // Leading-zero suppression: walk down from the most significant digit while
  // every digit seen so far is a plain zero (no dp, not blanked). Digit 0 is
  // never suppressed so a zero value still shows "0".
  always_comb begin
    zrun = 1'b1;
    sup  = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zrun   = zrun & (sh_val[i] == 4'h0) & ~sh_dp[i] & ~sh_bl[i];
      sup[i] = bus.lzs_en & zrun;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_DIGITS; g++) begin : g_lane
      sseg_digit u_lane (
        .nib  (sh_val[g]),
        .dp   (sh_dp[g]),
        .dark (sh_bl[g] | sup[g]),
        .pat  (lane_pat[g])
      );
    end
  endgenerate

  // One-hot digit select and AND-mux of active-low lane patterns.
  always_comb begin
    sel      = '0;
    sseg_mux = 8'hFF;
    for (int i = 0; i < N_DIGITS; i++) begin
      sel[i] = (idx == IW'(i));
      if (sel[i]) sseg_mux = sseg_mux & lane_pat[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q    <= '1;
      sseg_q  <= 8'hFF;
      frame_q <= 1'b0;
    end else begin
      frame_q <= fb;
      if (cnt < CW'(BLANK_CLKS)) begin
        an_q   <= '1;
        sseg_q <= 8'hFF;
      end else begin
        an_q   <= ~sel;
        sseg_q <= sseg_mux;
      end
    end
  end

  assign bus.an    = an_q;
  assign bus.sseg  = sseg_q;
  assign bus.frame = frame_q;
endmodule

// File: tb/tb_sseg_scan_driver.sv
module tb_sseg_scan_driver;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sseg_scan_driver_if #(.N_DIGITS(4)) bus0 ();
  sseg_scan_driver_if #(.N_DIGITS(1)) bus1 ();

  sseg_scan_driver #(.N_DIGITS(4), .CLKS_PER_DIGIT(8), .BLANK_CLKS(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  sseg_scan_driver #(.N_DIGITS(1), .CLKS_PER_DIGIT(4), .BLANK_CLKS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sseg;
  } slot_t;

  slot_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] s);
    slot_t e;
    e.an = a;
    e.sseg = s;
    exp_q.push_back(e);
  endtask

  task automatic push4(input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3);
    push(4'hE, s0);
    push(4'hD, s1);
    push(4'hB, s2);
    push(4'h7, s3);
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (bus0.frame === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_timeout: got no frame pulse, want one within 200 cycles");
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    bus0.value    = v;
    bus0.dp_in    = dp;
    bus0.blank_in = bl;
    bus0.load     = 1'b1;
    @(negedge clk);
    bus0.load     = 1'b0;
  endtask

  // Monitor: the first lit cycle of each slot is the DUT's "output event".
  initial begin
    logic [3:0] prev_an;
    slot_t e;
    prev_an = 4'hF;
    forever begin
      @(negedge clk);
      if (bus0.an !== 4'hF && prev_an === 4'hF && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus0.an !== e.an || bus0.sseg !== e.sseg) begin
          n_bad++;
          $display("FAIL slot: got an=%h sseg=%h want an=%h sseg=%h",
                   bus0.an, bus0.sseg, e.an, e.sseg);
        end
      end
      prev_an = bus0.an;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit hit;
    bus0.value = '0; bus0.dp_in = '0; bus0.blank_in = '0; bus0.lzs_en = 1'b0; bus0.load = 1'b0;
    bus1.value = '0; bus1.dp_in = '0; bus1.blank_in = '0; bus1.lzs_en = 1'b0; bus1.load = 1'b0;

    // 1: reset held with toggling inputs, then release latency
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus0.value  = 16'($urandom);
      bus0.dp_in  = 4'($urandom);
      bus0.load   = ~bus0.load;
      bus0.lzs_en = ~bus0.lzs_en;
      #1;
      chk("rst_an", bus0.an, 4'hF);
      chk("rst_sseg", bus0.sseg, 8'hFF);
      chk("rst_frame", bus0.frame, 1'b0);
    end
    chk("rst_an1", bus1.an, 1'b1);
    @(negedge clk);
    bus0.value = '0; bus0.dp_in = '0; bus0.load = 1'b0; bus0.lzs_en = 1'b0;
    reset_n = 1'b1;
    @(negedge clk); chk("rel_cyc1_an", bus0.an, 4'hF);
    @(negedge clk); chk("rel_cyc2_an", bus0.an, 4'hF);
    @(negedge clk); chk("rel_cyc3_an", bus0.an, 4'hE);
    chk("rel_cyc3_sseg", bus0.sseg, 8'hC0);

    // 2: load coincident with frame boundary, frame period
    wait_frame();
    repeat (31) @(negedge clk);
    bus0.value = 16'h1234; bus0.dp_in = '0; bus0.blank_in = '0; bus0.load = 1'b1;
    @(negedge clk);
    bus0.load = 1'b0;
    chk("frame_at_boundary_load", bus0.frame, 1'b1);
    push4(8'h99, 8'hB0, 8'hA4, 8'hF9);
    k = 0; hit = 1'b0;
    while (!hit && k < 64) begin
      @(negedge clk);
      k++;
      if (bus0.frame === 1'b1) hit = 1'b1;
    end
    chk("frame_period", k, 32);

    // 3: leading-zero suppression, then dp stops suppression
    do_load(16'h0007, 4'b0000, 4'b0000);
    bus0.lzs_en = 1'b1;
    wait_frame();
    push4(8'hF8, 8'hFF, 8'hFF, 8'hFF);
    wait_frame();
    do_load(16'h0007, 4'b0100, 4'b0000);
    wait_frame();
    push4(8'hF8, 8'hC0, 8'h40, 8'hFF);

    // 4: mid-frame load holds off until wrap; two loads -> last wins
    wait_frame();
    push4(8'hF8, 8'hC0, 8'h40, 8'hFF);
    do_load(16'hABCD, 4'b0000, 4'b0000);
    wait_frame();
    push4(8'hA1, 8'hC6, 8'h83, 8'h88);
    wait_frame();
    push4(8'hA1, 8'hC6, 8'h83, 8'h88);
    do_load(16'h1111, 4'b0000, 4'b0000);
    repeat (5) @(negedge clk);
    do_load(16'h2222, 4'b0000, 4'b0000);
    wait_frame();
    push4(8'hA4, 8'hA4, 8'hA4, 8'hA4);

    // 5: blank overrides digit but keeps dp; single-digit instance
    wait_frame();
    do_load(16'h2222, 4'b0100, 4'b0100);
    wait_frame();
    push4(8'hA4, 8'hA4, 8'h7F, 8'hA4);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (bus1.frame === 1'b1) hit = 1'b1;
    end
    chk("n1_frame_seen", hit, 1'b1);
    chk("n1_sseg", bus1.sseg, 8'hC0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk("n1_an", bus1.an, (i % 4 == 1) ? 1 : 0);
      chk("n1_frame", bus1.frame, (i % 4 == 0) ? 1 : 0);
    end

    // 6: async reset mid-slot at idx 2, restart from idx 0 with shadow cleared
    wait_frame();
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(negedge clk);
      if (bus0.an === 4'b1011) hit = 1'b1;
    end
    chk("idx2_reached", hit, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_an", bus0.an, 4'hF);
    chk("async_rst_sseg", bus0.sseg, 8'hFF);
    chk("async_rst_frame", bus0.frame, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    push4(8'hC0, 8'hFF, 8'hFF, 8'hFF);
    @(negedge clk); chk("restart_cyc1_an", bus0.an, 4'hF);
    @(negedge clk); chk("restart_cyc2_an", bus0.an, 4'hF);
    @(negedge clk); chk("restart_cyc3_an", bus0.an, 4'hE);
    wait_frame();
    @(negedge clk);

    chk("scoreboard_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
